layer_out_collector: RTL and testbench



---
 rtl/layer_out_collector_pkg.sv | 19 +
 rtl/layer_out_collector_if.sv | 40 ++++
 rtl/layer_out_collector_frame_bank.sv | 44 ++++
 rtl/layer_out_collector.sv | 113 +++++++++++
 tb/tb_layer_out_collector.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_out_collector_pkg.sv
// Shared widths and types for the layer output collector.
// A frame is M signed words of width T; IW indexes a word within a frame.
package layer_collect_pkg;

  localparam int unsigned T  = 16;
  localparam int unsigned M  = 6;
  localparam int unsigned IW = $clog2(M);

  typedef logic signed [T-1:0] word_t;
  typedef logic [IW-1:0]       idx_t;

  localparam idx_t LastIdx = idx_t'(M - 1);

  // IW can encode indices past the end of the frame when M is not a power of two.
  function automatic logic addr_in_range(input idx_t addr);
    return addr <= LastIdx;
  endfunction

endpackage

// File: rtl/layer_out_collector_if.sv
// Upstream word stream plus downstream frame handshake and read port.
// The slave modport is the collector side; master is the pipeline/consumer side.
interface layer_out_collector_if;
  import layer_collect_pkg::*;

  logic  s_valid;
  logic  s_ready;
  word_t data_in;
  logic  f_valid;
  logic  f_ready;
  idx_t  f_argmax;
  word_t f_max;
  idx_t  rd_addr;
  word_t rd_data;

  modport slave (
    input  s_valid,
    input  data_in,
    input  f_ready,
    input  rd_addr,
    output s_ready,
    output f_valid,
    output f_argmax,
    output f_max,
    output rd_data
  );

  modport master (
    output s_valid,
    output data_in,
    output f_ready,
    output rd_addr,
    input  s_ready,
    input  f_valid,
    input  f_argmax,
    input  f_max,
    input  rd_data
  );

endinterface

// File: rtl/layer_out_collector_frame_bank.sv
// One half of the ping-pong frame buffer: M word registers with a combinational
// read port, plus the frame's argmax result registers.
module frame_bank
  import layer_collect_pkg::*;
(
  input  logic  clk,
  input  logic  i_we,
  input  idx_t  i_wr_idx,
  input  word_t i_wr_data,
  input  logic  i_res_we,
  input  word_t i_res_max,
  input  idx_t  i_res_idx,
  input  idx_t  i_rd_addr,
  output word_t o_rd_data,
  output word_t o_max,
  output idx_t  o_idx
);

  word_t r_mem [M];
  word_t r_max;
  idx_t  r_idx;

  // Contents are qualified by the owner's full flag, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
    if (i_res_we) begin
      r_max <= i_res_max;
      r_idx <= i_res_idx;
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (addr_in_range(i_rd_addr)) begin
      o_rd_data = r_mem[i_rd_addr];
    end
  end

  assign o_max = r_max;
  assign o_idx = r_idx;

endmodule

// File: rtl/layer_out_collector.sv
// Receive endpoint for the last layer: collects M-word frames into a ping-pong
// buffer, tracks a signed argmax per frame and presents completed frames in order.
module layer_out_collector
  import layer_collect_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  layer_out_collector_if.slave   lo_if
);

  logic [1:0] r_full;
  logic [1:0] w_full_d;
  logic       r_wr_bank;
  logic       r_rd_bank;
  idx_t       r_wr_idx;
  word_t      r_run_max;
  idx_t       r_run_idx;

  logic       w_s_ready;
  logic       w_f_valid;
  logic       w_accept;
  logic       w_pop;
  logic       w_last;
  word_t      w_max_d;
  idx_t       w_idx_d;
  logic [1:0] w_we;

  word_t      w_rd_data  [2];
  word_t      w_bank_max [2];
  idx_t       w_bank_idx [2];

  assign w_s_ready = !r_full[r_wr_bank];
  assign w_f_valid = r_full[r_rd_bank];
  assign w_accept  = lo_if.s_valid && w_s_ready;
  assign w_pop     = w_f_valid && lo_if.f_ready;
  assign w_last    = (r_wr_idx == LastIdx);

  // Running argmax including the word being accepted; strict > keeps the lowest index on ties.
  always_comb begin
    w_max_d = r_run_max;
    w_idx_d = r_run_idx;
    if (r_wr_idx == '0) begin
      w_max_d = lo_if.data_in;
      w_idx_d = '0;
    end else if (lo_if.data_in > r_run_max) begin
      w_max_d = lo_if.data_in;
      w_idx_d = r_wr_idx;
    end
  end

  // Set and clear never hit the same bank: accept needs it empty, pop needs it full.
  always_comb begin
    w_full_d = r_full;
    if (w_accept && w_last) begin
      w_full_d[r_wr_bank] = 1'b1;
    end
    if (w_pop) begin
      w_full_d[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_run_max <= '0;
      r_run_idx <= '0;
    end else begin
      r_full <= w_full_d;
      if (w_pop) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_accept) begin
        r_run_max <= w_max_d;
        r_run_idx <= w_idx_d;
        if (w_last) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  assign w_we[0] = w_accept && !r_wr_bank;
  assign w_we[1] = w_accept &&  r_wr_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank u_bank (
      .clk       (clk),
      .i_we      (w_we[b]),
      .i_wr_idx  (r_wr_idx),
      .i_wr_data (lo_if.data_in),
      .i_res_we  (w_we[b] && w_last),
      .i_res_max (w_max_d),
      .i_res_idx (w_idx_d),
      .i_rd_addr (lo_if.rd_addr),
      .o_rd_data (w_rd_data[b]),
      .o_max     (w_bank_max[b]),
      .o_idx     (w_bank_idx[b])
    );
  end

  assign lo_if.s_ready  = w_s_ready;
  assign lo_if.f_valid  = w_f_valid;
  assign lo_if.f_max    = w_f_valid ? w_bank_max[r_rd_bank] : '0;
  assign lo_if.f_argmax = w_f_valid ? w_bank_idx[r_rd_bank] : '0;
  assign lo_if.rd_data  = w_f_valid ? w_rd_data[r_rd_bank]  : '0;

endmodule

// File: tb/tb_layer_out_collector.sv
// Scoreboard bench for layer_out_collector: expected frames are queued as they are
// driven and compared (max, argmax, every word) when the collector presents them.
module tb_layer_out_collector;
  import layer_collect_pkg::*;

  localparam int Half = 20;

  typedef struct {
    word_t w [M];
    word_t mx;
    idx_t  ix;
  } frame_t;

  logic clk = 1'b0;
  logic reset;

  always #Half clk = ~clk;

  layer_out_collector_if u_if ();

  layer_out_collector u_dut (
    .clk   (clk),
    .reset (reset),
    .lo_if (u_if)
  );

  frame_t sb_q [$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     acc_cnt  = 0;
  bit     abort    = 1'b0;

  // Inputs change only at posedge+1, so a handshake seen at negedge completes at the next edge.
  always @(negedge clk) begin
    if (!reset && u_if.s_valid && u_if.s_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic frame_t finish_frame(input frame_t f);
    frame_t r = f;
    r.mx = f.w[0];
    r.ix = '0;
    for (int i = 1; i < M; i++) begin
      if (f.w[i] > r.mx) begin
        r.mx = f.w[i];
        r.ix = idx_t'(i);
      end
    end
    return r;
  endfunction

  function automatic frame_t frm(input int a, input int b, input int c,
                                 input int d, input int e, input int g);
    frame_t f;
    f.w[0] = word_t'(a); f.w[1] = word_t'(b); f.w[2] = word_t'(c);
    f.w[3] = word_t'(d); f.w[4] = word_t'(e); f.w[5] = word_t'(g);
    f.mx = '0;
    f.ix = '0;
    return finish_frame(f);
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < M; i++) f.w[i] = word_t'(int'($urandom_range(40)) - 20);
    f.mx = '0;
    f.ix = '0;
    return finish_frame(f);
  endfunction

  // Entered and left at posedge+1; holds the word until the collector takes it.
  task automatic send_word(input word_t w, output bit ok);
    int   cyc = 0;
    logic rdy = 1'b0;
    ok = 1'b0;
    u_if.s_valid = 1'b1;
    u_if.data_in = w;
    while (!ok && cyc < 300) begin
      @(negedge clk);
      rdy = u_if.s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) ok = 1'b1;
    end
    if (!ok) begin
      check_eq("send_timeout", 0, 1);
      abort = 1'b1;
    end
  endtask

  task automatic drive_frame(input frame_t f, input int gap_pct, input bit pop_at_last);
    bit ok;
    sb_q.push_back(f);
    for (int i = 0; i < M && !abort; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        u_if.s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (pop_at_last && i == M - 1) u_if.f_ready = 1'b1;
      send_word(f.w[i], ok);
      if (pop_at_last && i == M - 1) u_if.f_ready = 1'b0;
    end
    u_if.s_valid = 1'b0;
  endtask

  // Called just after a negedge; finishes within the low phase of the clock.
  task automatic sweep_check(input string tag);
    frame_t e;
    int     exp;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q[0];
      check_eq({tag, "_f_valid"}, int'(u_if.f_valid), 1);
      check_eq({tag, "_f_max"}, int'(u_if.f_max), int'(e.mx));
      check_eq({tag, "_f_argmax"}, int'(u_if.f_argmax), int'(e.ix));
      for (int a = 0; a < M + 2; a++) begin
        u_if.rd_addr = idx_t'(a);
        exp = (a < M) ? int'(e.w[a]) : 0;
        #2;
        check_eq({tag, "_rd_data"}, int'(u_if.rd_data), exp);
      end
    end
  endtask

  task automatic check_front(input string tag);
    @(negedge clk);
    sweep_check(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_frame();
    u_if.f_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.f_ready = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_front());
  endtask

  initial begin
    #(2 * Half * 60000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    int cyc;
    bit d3_done;

    reset        = 1'b1;
    u_if.s_valid = 1'b0;
    u_if.data_in = '0;
    u_if.f_ready = 1'b0;
    u_if.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check_eq("rst_s_ready", int'(u_if.s_ready), 1);
    check_eq("rst_f_valid", int'(u_if.f_valid), 0);
    check_eq("rst_f_argmax", int'(u_if.f_argmax), 0);
    check_eq("rst_f_max", int'(u_if.f_max), 0);
    check_eq("rst_rd_data", int'(u_if.rd_data), 0);
    @(posedge clk);
    #1;

    // Tie at 12 keeps index 2; f_ready high before the frame exists has no effect.
    u_if.f_ready = 1'b1;
    drive_frame(frm(5, -3, 12, 7, 12, 0), 0, 1'b0);
    @(negedge clk);
    sweep_check("single");
    @(posedge clk);
    #1;
    u_if.f_ready = 1'b0;
    void'(sb_q.pop_front());
    @(negedge clk);
    check_eq("single_popped_valid", int'(u_if.f_valid), 0);
    check_eq("single_popped_max", int'(u_if.f_max), 0);
    check_eq("single_popped_rd", int'(u_if.rd_data), 0);
    @(posedge clk);
    #1;

    drive_frame(frm(-9, -2, -50, -2, -7, -100), 0, 1'b0);
    check_front("negative");
    pop_frame();

    // Three frames against a stalled consumer.
    base    = acc_cnt;
    d3_done = 1'b0;
    fork
      begin
        drive_frame(frm(1, 9, 3, 9, 0, -1), 0, 1'b0);
        drive_frame(frm(-4, -4, -4, -4, -4, -4), 0, 1'b0);
        drive_frame(frm(7, 6, 5, 4, 3, 8), 0, 1'b0);
        d3_done = 1'b1;
      end
    join_none
    cyc = 0;
    while (acc_cnt < base + 12 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_eq("stall_reached_12", acc_cnt - base, 12);
    @(negedge clk);
    check_eq("stall_s_ready", int'(u_if.s_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("stall_hold_s_ready", int'(u_if.s_ready), 0);
    check_eq("stall_no_extra_accept", acc_cnt - base, 12);
    @(posedge clk);
    #1;
    check_front("stall_f1");
    u_if.f_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_ready_not_comb", int'(u_if.s_ready), 0);
    @(posedge clk);
    #1;
    u_if.f_ready = 1'b0;
    void'(sb_q.pop_front());
    @(negedge clk);
    check_eq("stall_s_ready_rises", int'(u_if.s_ready), 1);
    @(posedge clk);
    #1;
    check_front("stall_f2");
    cyc = 0;
    while (!d3_done && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_eq("stall_f3_sent", int'(d3_done), 1);
    pop_frame();
    check_front("stall_f3");
    pop_frame();

    // Pop of A coincides with B's last word; B's max sits in the last slot.
    drive_frame(frm(3, 30, -8, 30, 2, 1), 0, 1'b0);
    check_front("overlap_a");
    drive_frame(frm(1, 2, 3, 4, 5, 99), 0, 1'b1);
    void'(sb_q.pop_front());
    check_front("overlap_b");
    pop_frame();

    // Random gaps and random consumer readiness.
    fork
      begin
        for (int n = 0; n < 200 && !abort; n++) drive_frame(rand_frame(), 30, 1'b0);
      end
      begin
        int  got     = 0;
        int  rcyc    = 0;
        bit  checked = 1'b0;
        while (got < 200 && rcyc < 30000) begin
          @(negedge clk);
          rcyc++;
          if (u_if.f_valid) begin
            if (!checked) begin
              sweep_check("rand");
              checked = 1'b1;
            end
            u_if.f_ready = 1'($urandom_range(1));
            if (u_if.f_ready) begin
              void'(sb_q.pop_front());
              got++;
              checked = 1'b0;
            end
          end else begin
            u_if.f_ready = 1'($urandom_range(1));
          end
        end
        @(posedge clk);
        #1;
        u_if.f_ready = 1'b0;
        check_eq("rand_frames", got, 200);
      end
    join

    // Reset with one frame pending and three words of the next in flight.
    drive_frame(frm(11, 12, 13, 14, 15, 16), 0, 1'b0);
    send_word(word_t'(100), ok);
    send_word(word_t'(100), ok);
    send_word(word_t'(100), ok);
    u_if.s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_f_valid", int'(u_if.f_valid), 0);
    check_eq("mid_rst_s_ready", int'(u_if.s_ready), 1);
    check_eq("mid_rst_f_max", int'(u_if.f_max), 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    drive_frame(frm(40, -1, 2, 40, 4, 5), 0, 1'b0);
    check_front("fresh");
    pop_frame();
    @(negedge clk);
    check_eq("end_f_valid", int'(u_if.f_valid), 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
